poly_arb: RTL
=============

// Module: poly_arb
// PURPOSE
//  Round-robin scheduler sharing one poly_fun datapath (fixed latency, non-stallable) among NREQ requesters.
//  Accepts x operands over per-requester valid/ready, issues at most one per cycle to the datapath.
//  Tracks in-flight tags and returns each y to its originator via a held valid/ready response register.
//  Sits between client blocks and a single poly_fun instance at the same level of the hierarchy.
// PARAMETERS
//  NREQ   4   number of requesters (2..16)
//  WIDTH  16  operand/result width; must match the datapath WIDTH
//  LAT    2   cycles from issue cycle T until dp_y valid (cycle T+LAT); poly_fun = 2
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  req_valid  in   NREQ         requester i presents an operand
//  req_ready  out  NREQ         one-hot grant; handshake when req_valid[i] && req_ready[i]
//  req_x      in   NREQ*WIDTH   signed operands, requester i at [i*WIDTH +: WIDTH]
//  rsp_valid  out  NREQ         result held for requester i
//  rsp_ready  in   NREQ         requester i consumes result
//  rsp_y      out  NREQ*WIDTH   signed results, same packing as req_x
//  dp_x       out  WIDTH        operand to datapath x (combinational from granted req_x)
//  dp_y       in   WIDTH        datapath y, sampled in cycle T+LAT
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_y=0, tag pipeline valid bits=0, rr pointer=0; req_ready=0, dp_x=0 while rst_n low.
//  Eligible[i] = req_valid[i] && !inflight[i] && !rsp_valid[i]: at most one outstanding op per requester.
//  Grant: combinational round-robin over Eligible, starting search at pointer; req_ready = one-hot grant or 0.
//  On grant to g: dp_x = req_x[g]; pointer <= (g+1) mod NREQ; tag stage 0 <= {1,g}; inflight[g] <= 1.
//  No grant: dp_x = 0; tag stage 0 <= {0,-}; pointer holds.
//  Tag pipeline: LAT-deep shift register of {valid, index}, advances every cycle; never stalls.
//  When stage LAT-1 valid with index k: rsp_y[k] <= dp_y, rsp_valid[k] <= 1, inflight[k] <= 0.
//  Response visible from cycle T+LAT+1; latency req handshake -> rsp_valid = LAT+1 cycles (3 default).
//  rsp_valid[i] holds and rsp_y[i] stable until rsp_valid[i] && rsp_ready[i]; then clears next edge.
//  Requester i re-eligible the cycle after its response is consumed (no same-cycle bypass).
//  Result write and consume for the same i cannot coincide (one outstanding); no collision logic needed.
//  Throughput: one issue/cycle overall; back-to-back issues from distinct requesters every cycle.
//  Arithmetic: none; dp_y passes through unmodified (datapath wraparound is the client's concern).
//  Reset mid-operation: in-flight tags and held results discarded; stale dp_y ignored after release.
//  NREQ=1: pointer constant 0; single requester, max one op per LAT+2 cycles.
// CONFIGURATION
//  POLY_ARB_STATS_EN defined: adds outputs stat_issues[31:0] (+1 per grant) and
//   stat_stalls[31:0] (+1 per cycle with |req_valid && no grant); both wrap at 2^32, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package poly_arb_pkg: typedef tag_t {logic vld; logic [$clog2(NREQ)-1:0] idx;},
//   localparam STAT_W = 32, function rr_pick(req, ptr) returning one-hot grant.
//  Sub-module rr_arbiter (NREQ): eligible + pointer in, one-hot grant + grant index out; pointer register in parent.
//  Parent holds tag pipeline, inflight/rsp registers, optional stat counters.
// TESTING (bench instantiates poly_arb + poly_fun W2=3,W1=2,W0=4, WIDTH=16, NREQ=4; poly_fun.rst = ~rst_n)
//  Single op: req0 x=5 at T -> rsp_valid[0] at T+3, rsp_y[0]=89; held while rsp_ready[0]=0 for 4 cycles.
//  Fairness: all 4 req_valid, rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles, then 0 after its rsp consumed.
//  One outstanding: req1 holds valid, rsp_ready[1]=0 -> no second grant to 1 until consumed; others still served.
//  Wraparound passthrough: x=-200 -> rsp_y = 16-bit wrap of 3*40000-400+4 (poly_fun model), signed compare.
//  Reset mid-flight: rst_n low at T+1 after issue -> rsp_valid=0 throughout, no response after release.
//  Stats (POLY_ARB_STATS_EN): 3 grants + 2 blocked cycles -> stat_issues=3, stat_stalls=2; build without macro too.

Source files
------------

// File: rtl/poly_arb_pkg.sv
// poly_arb_pkg: shared types and helpers for the poly_arb scheduler.
//   tag_t    : one stage of the in-flight tag pipeline {vld, idx}
//   STAT_W   : width of the optional statistics counters
//   rr_pick  : round-robin pick over a request vector, returns a one-hot grant
// The index width is sized for the largest supported requester count (16),
// so one package serves every NREQ in the 1..16 range.
package poly_arb_pkg;

   localparam int MAX_NREQ = 16;
   localparam int IDX_W    = $clog2(MAX_NREQ);
   localparam int STAT_W   = 32;

   typedef struct packed {
      logic             vld;
      logic [IDX_W-1:0] idx;
   } tag_t;

   // Search req[] starting at ptr, wrapping at n; first hit wins.
   // Only the low n bits of req are considered. ptr must be < n.
   function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                   input logic [IDX_W-1:0]    ptr,
                                                   input int                  n);
      logic [MAX_NREQ-1:0] gnt;
      logic                found;
      int                  j;
      logic [IDX_W-1:0]    jj;
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= n) j = j - n;
         jj = j[IDX_W-1:0];
         if (k < n && !found && req[jj]) begin
            gnt[jj] = 1'b1;
            found   = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/poly_arb_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   eligible  [NREQ]  in  : requesters allowed to win this cycle
//   ptr       [IDX_W] in  : index where the search starts (register lives in parent)
//   grant     [NREQ]  out : one-hot grant, all zero when nothing is eligible
//   grant_idx [IDX_W] out : binary index of the granted requester (0 if none)
//   grant_vld         out : any grant this cycle
module rr_arbiter
   import poly_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]  eligible,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   logic [MAX_NREQ-1:0] req_pad;
   logic [MAX_NREQ-1:0] pick;

   always_comb begin
      req_pad             = '0;
      req_pad[NREQ-1:0]   = eligible;
      pick                = rr_pick(req_pad, ptr, NREQ);
      grant               = pick[NREQ-1:0];
      grant_vld           = |pick;
      grant_idx           = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) grant_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/poly_arb.sv
// poly_arb: round-robin scheduler sharing one fixed-latency, non-stallable
// datapath among NREQ requesters, returning each result to its originator.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/ready/x     : per-requester operand input (x packed WIDTH per requester)
//   rsp_valid/ready/y     : per-requester held result output (same packing)
//   dp_x                  : operand to the datapath (combinational from the granted req_x)
//   dp_y                  : datapath result, valid LAT cycles after issue
//   stat_issues/stalls    : present only when POLY_ARB_STATS_EN is defined
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid may not depend on ready, a producer holds its data until
// the transfer, and rsp_valid/rsp_y stay stable until consumed.
// Each requester has at most one operation outstanding (in flight or held
// as a result), so a result write and a consume never hit the same slot.
module poly_arb
   import poly_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16,
   parameter int LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_x,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [NREQ*WIDTH-1:0] rsp_y,
   output logic [WIDTH-1:0]      dp_x,
   input  logic [WIDTH-1:0]      dp_y
`ifdef POLY_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_issues,
   output logic [STAT_W-1:0]     stat_stalls
`endif
);

   logic [NREQ-1:0]  inflight_q, inflight_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_y_q [NREQ];
   logic [WIDTH-1:0] rsp_y_d [NREQ];
   logic [IDX_W-1:0] ptr_q, ptr_d;
   tag_t             tag_q [LAT];
   tag_t             tag_d [LAT];

   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  arb_grant, grant;
   logic [IDX_W-1:0] grant_idx;
   logic             arb_vld, grant_vld;

   assign eligible = req_valid & ~inflight_q & ~rsp_valid_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .eligible  (eligible),
      .ptr       (ptr_q),
      .grant     (arb_grant),
      .grant_idx (grant_idx),
      .grant_vld (arb_vld)
   );

   always_comb begin
      // No grant may be seen while reset is asserted.
      grant       = rst_n ? arb_grant : '0;
      grant_vld   = rst_n & arb_vld;
      req_ready   = grant;
      dp_x        = '0;
      ptr_d       = ptr_q;
      inflight_d  = inflight_q;
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;

      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) dp_x = req_x[i*WIDTH +: WIDTH];
      end

      if (grant_vld) begin
         ptr_d = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end

      tag_d[0].vld = grant_vld;
      tag_d[0].idx = grant_vld ? grant_idx : '0;
      for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];

      for (int i = 0; i < NREQ; i++) begin
         if (rsp_valid_q[i] && rsp_ready[i]) rsp_valid_d[i] = 1'b0;
         // Last tag stage lines up with dp_y for the op issued LAT cycles ago.
         if (tag_q[LAT-1].vld && tag_q[LAT-1].idx == IDX_W'(i)) begin
            rsp_valid_d[i] = 1'b1;
            rsp_y_d[i]     = dp_y;
            inflight_d[i]  = 1'b0;
         end
         if (grant[i]) inflight_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q  <= '0;
         rsp_valid_q <= '0;
         ptr_q       <= '0;
         for (int i = 0; i < NREQ; i++) rsp_y_q[i] <= '0;
         for (int s = 0; s < LAT; s++)  tag_q[s]   <= '0;
      end else begin
         inflight_q  <= inflight_d;
         rsp_valid_q <= rsp_valid_d;
         ptr_q       <= ptr_d;
         rsp_y_q     <= rsp_y_d;
         tag_q       <= tag_d;
      end
   end

   assign rsp_valid = rsp_valid_q;

   for (genvar g = 0; g < NREQ; g++) begin : g_rsp_y
      assign rsp_y[g*WIDTH +: WIDTH] = rsp_y_q[g];
   end

`ifdef POLY_ARB_STATS_EN
   logic [STAT_W-1:0] stat_issues_q, stat_issues_d;
   logic [STAT_W-1:0] stat_stalls_q, stat_stalls_d;

   always_comb begin
      stat_issues_d = stat_issues_q + {{(STAT_W-1){1'b0}}, grant_vld};
      stat_stalls_d = stat_stalls_q + {{(STAT_W-1){1'b0}}, (|req_valid) & ~grant_vld};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issues_q <= '0;
         stat_stalls_q <= '0;
      end else begin
         stat_issues_q <= stat_issues_d;
         stat_stalls_q <= stat_stalls_d;
      end
   end

   assign stat_issues = stat_issues_q;
   assign stat_stalls = stat_stalls_q;
`endif

endmodule
